pc_next_stage: RTL
==================

# pc_next_stage

Fetch-side program-counter stage of the pipelined CPU. Holds the architectural fetch PC and selects the next PC from sequential increment, a resolved conditional branch (consuming the comparator's less/equal/greater flags from decode), a jump, or a return popped from a small return-address stack. It drives the instruction-memory address and the IF/ID flush request.

## Interface
Parameters:
- n, 32, PC and address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- clear  input  1  reset, synchronous, active-high.
- stall  input  1  hold PC and stack; redirect inputs ignored.
- decode_pc  input  n  PC of the instruction currently in decode.
- br_valid  input  1  decode holds a conditional branch.
- br_cond  input  3  condition code.
- less, equal, greater  input  1 each  comparator flags for the branch operands.
- br_target  input  n  branch target.
- jump_valid  input  1  unconditional jump, or call, in decode.
- call  input  1  qualifies jump_valid; push return address.
- jump_target  input  n  jump/call target.
- ret  input  1  return in decode.
- pc  output  n  registered fetch PC; instruction-memory address.
- flush  output  1  combinational; kill the IF/ID contents at the next edge.
- ras_underflow  output  1  registered one-cycle pulse: ret on an empty stack.
- redirect_count  output  16  saturating count of redirects.

## Operation
- Condition codes: 000 EQ equal. 001 NE !equal. 010 LT less. 011 GE greater|equal. 100 GT greater. 101 LE less|equal. 110 always. 111 never.
- taken = br_valid & cond_true(br_cond).
- Next-PC priority: clear > stall > ret > jump_valid > taken > pc+1.
- clear: pc=RESET_PC, stack count=0, pointer=0, entries=0, ras_underflow=0, redirect_count=0.
- stall: every register holds; flush=0.
- ret, stack non-empty: next pc=top entry; pop.
- ret, stack empty: next pc=decode_pc+1; ras_underflow pulses for one cycle.
- jump_valid: next pc=jump_target. If call is also high, push decode_pc+1.
- Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
- ret together with call: ret wins; no push.
- taken: next pc=br_target.
- flush = !stall & (ret | jump_valid | taken). redirect_count increments on flush and saturates at 16'hFFFF.
- Addition is modulo 2^n: pc+1 wraps from all-ones to 0. Unsigned.

## Timing
- Redirect decided in cycle t (flush high in t) → pc = target after edge t+1.
- With no redirect, pc advances by 1 per unstalled cycle.
- flush is combinational from the inputs. No registered latency.
- ras_underflow is high during cycle t+1 for a ret in cycle t.
- clear high at any edge, including mid-redirect, overrides everything. The first fetch after release is RESET_PC.
- Stack state is visible to a ret in the cycle immediately after a push (no bypass within a cycle).

## Structure
- Shared package holds the br_cond encodings (COND_EQ…COND_NEVER) and the RAS_DEPTH default.
- Sub-module return_stack holds the circular buffer, pointer, and count.
  - Inputs: push, pop, push_data. Outputs: top, empty.
  - Synchronous clear.
- Reuse the existing general adder for the pc+1 and decode_pc+1 increments.

## Test plan
- Reset then 4 unstalled cycles → pc 0,1,2,3,4. flush=0 throughout.
- Branch: br_valid=1, br_cond=010, less=1, br_target=0x40 at pc=5.
  - flush=1 that cycle; next pc=0x40; redirect_count=1.
- Same branch with greater=1 instead → no flush; pc=6.
- Call/return sequence:
  - jump_valid=1, call=1, decode_pc=0x10, jump_target=0x80 → pc=0x80.
  - Later ret → pc=0x11, stack empty.
  - Second ret → pc=decode_pc+1; ras_underflow pulses once.
- Overflow: 5 calls with RAS_DEPTH=4 (decode_pc 1..5) → 4 rets return 6,5,4,3.
  - A 5th ret underflows.
- stall=1 with taken branch asserted → pc held, flush=0.
  - clear pulse mid-stall → pc=RESET_PC next cycle, count=0.

Source files
------------

// File: rtl/pc_next_stage_pkg.sv
// Purpose: shared branch-condition encodings, RAS default depth and condition evaluator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pc_next_stage_pkg;

    localparam int RAS_DEPTH_DEFAULT = 4;

    localparam logic [2:0] COND_EQ    = 3'b000;
    localparam logic [2:0] COND_NE    = 3'b001;
    localparam logic [2:0] COND_LT    = 3'b010;
    localparam logic [2:0] COND_GE    = 3'b011;
    localparam logic [2:0] COND_GT    = 3'b100;
    localparam logic [2:0] COND_LE    = 3'b101;
    localparam logic [2:0] COND_ALWAYS = 3'b110;
    localparam logic [2:0] COND_NEVER = 3'b111;

    // Resolve a condition code against the comparator flags from decode.
    function automatic logic cond_true(input logic [2:0] cond,
                                       input logic       less,
                                       input logic       equal,
                                       input logic       greater);
        logic res;
        res = 1'b0;
        case (cond)
            COND_EQ:     res = equal;
            COND_NE:     res = !equal;
            COND_LT:     res = less;
            COND_GE:     res = greater | equal;
            COND_GT:     res = greater;
            COND_LE:     res = less | equal;
            COND_ALWAYS: res = 1'b1;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/adder.sv
// Purpose: general unsigned W-bit adder, sum wraps modulo 2^W.
// Latency: combinational.
// Backpressure: none.
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    // Carry out is intentionally dropped so the result wraps.
    always_comb begin
        sum = a + b;
    end

endmodule

// File: rtl/return_stack.sv
// Purpose: circular return-address stack; pushing when full overwrites the oldest entry.
// Latency: push/pop take effect at the next edge; top/empty reflect registered state only.
// Backpressure: none; pop on an empty stack is ignored, pop has priority over push.
module return_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int             PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     entry_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_dec;
    logic [PTR_W:0]   count_q, count_d;

    // ptr_q addresses the next free slot, so the top lives one below it.
    always_comb begin
        ptr_dec = ptr_q - 1'b1;
        top     = entry_q[ptr_dec];
        empty   = (count_q == '0);
    end

    // Pointer/count next state; count saturates so a wrapped push keeps depth at DEPTH.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (pop && !empty) begin
            ptr_d   = ptr_dec;
            count_d = count_q - 1'b1;
        end else if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (count_q != FULL) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // State update with synchronous clear of pointer, count and entries.
    always_ff @(posedge clk) begin
        if (clear) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (push && !(pop && !empty)) begin
                entry_q[ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_next_stage.sv
// Purpose: fetch PC register and next-PC select (ret > jump/call > taken branch > pc+1).
// Latency: redirect in cycle t lands in pc after edge t+1; flush is combinational.
// Backpressure: stall holds every register and suppresses flush; clear overrides stall.
module pc_next_stage
    import pc_next_stage_pkg::*;
#(
    parameter int           n         = 32,
    parameter logic [n-1:0] RESET_PC  = '0,
    parameter int           RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         stall,
    input  logic [n-1:0] decode_pc,
    input  logic         br_valid,
    input  logic [2:0]   br_cond,
    input  logic         less,
    input  logic         equal,
    input  logic         greater,
    input  logic [n-1:0] br_target,
    input  logic         jump_valid,
    input  logic         call,
    input  logic [n-1:0] jump_target,
    input  logic         ret,
    output logic [n-1:0] pc,
    output logic         flush,
    output logic         ras_underflow,
    output logic [15:0]  redirect_count
);

    localparam logic [n-1:0] ONE = n'(1);

    logic [n-1:0] pc_q, pc_d;
    logic         uf_q, uf_d;
    logic [15:0]  cnt_q, cnt_d;

    logic [n-1:0] pc_plus1, dec_plus1, ras_top;
    logic         ras_empty, ras_push, ras_pop;
    logic         taken, redirect;

    adder #(.W(n)) u_pc_inc (
        .a   (pc_q),
        .b   (ONE),
        .sum (pc_plus1)
    );

    adder #(.W(n)) u_dec_inc (
        .a   (decode_pc),
        .b   (ONE),
        .sum (dec_plus1)
    );

    return_stack #(.W(n), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .clear     (clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (dec_plus1),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // Redirect decode; ret suppresses a simultaneous call push.
    always_comb begin
        taken    = br_valid & cond_true(br_cond, less, equal, greater);
        redirect = ret | jump_valid | taken;
        flush    = !stall & redirect;
        ras_push = !stall & !ret & jump_valid & call;
        ras_pop  = !stall & ret & !ras_empty;
    end

    // Next-PC select in priority order; an empty-stack ret falls through to decode_pc+1.
    always_comb begin
        pc_d  = pc_plus1;
        uf_d  = 1'b0;
        cnt_d = (cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        if (ret) begin
            if (ras_empty) begin
                pc_d = dec_plus1;
                uf_d = 1'b1;
            end else begin
                pc_d = ras_top;
            end
        end else if (jump_valid) begin
            pc_d = jump_target;
        end else if (taken) begin
            pc_d = br_target;
        end
    end

    // Registered state; clear beats stall, stall freezes everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            pc_q  <= RESET_PC;
            uf_q  <= 1'b0;
            cnt_q <= '0;
        end else if (!stall) begin
            pc_q <= pc_d;
            uf_q <= uf_d;
            if (redirect) begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        pc             = pc_q;
        ras_underflow  = uf_q;
        redirect_count = cnt_q;
    end

endmodule
